// File: rtl/cheri_regfile_clear_ctrl.sv
// Arbitrates the CHERI register-file write port between commit writeback and queued quarter-clears.
// Optional build macro CHERI_CLR_MERGE_EN folds same-quarter requests into the FIFO tail entry.
module cheri_regfile_clear_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int NR_READ_PORTS = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clr_valid_i,
   output logic                          clr_ready_o,
   input  logic [1:0]                    clr_quarter_i,
   input  logic [7:0]                    clr_mask_i,
   input  logic                          commit_we_i,
   input  logic [4:0]                    commit_waddr_i,
   input  logic [DATA_WIDTH-1:0]         commit_wdata_i,
   output logic                          rf_we_o,
   output logic                          rf_clr_o,
   output logic [4:0]                    rf_waddr_o,
   output logic [DATA_WIDTH-1:0]         rf_wdata_o,
   output logic [7:0]                    rf_mask_o,
   output logic [1:0]                    rf_quarter_o,
   input  logic [NR_READ_PORTS-1:0][4:0] raddr_i,
   output logic [NR_READ_PORTS-1:0]      hazard_o,
   output logic [31:0]                   pending_o,
   output logic                          busy_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   logic [7:0]    q_mask    [FIFO_DEPTH];
   logic [1:0]    q_quarter [FIFO_DEPTH];
   logic [7:0]    q_mask_stripped [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
   logic [PW:0]   count;

   logic       full, empty, accept, pop, merge, alloc, strip_en;
   logic [7:0] strip_bit, req_mask, head_mask;
   logic [31:0] pend;

   always_comb begin
      full      = (count == DEPTH_C);
      empty     = (count == '0);
      tail_ptr  = wr_ptr - 1'b1;
      strip_en  = commit_we_i && (commit_waddr_i != 5'd0);
      strip_bit = 8'b1 << commit_waddr_i[2:0];
      accept    = clr_valid_i && !full;
      pop       = !commit_we_i && !empty;
      head_mask = q_mask[rd_ptr];
      // A same-cycle request is older than the commit, so it loses the committed register's bit too
      req_mask  = clr_mask_i;
      if (strip_en && (clr_quarter_i == commit_waddr_i[4:3])) begin
         req_mask = clr_mask_i & ~strip_bit;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         q_mask_stripped[i] = q_mask[i];
         if (strip_en && (q_quarter[i] == commit_waddr_i[4:3])) begin
            q_mask_stripped[i] = q_mask[i] & ~strip_bit;
         end
      end
`ifdef CHERI_CLR_MERGE_EN
      merge = accept && (req_mask != 8'h00) && !empty &&
              (q_quarter[tail_ptr] == clr_quarter_i) &&
              !(pop && (count == (PW+1)'(1)));
`else
      merge = 1'b0;
`endif
      alloc = accept && (req_mask != 8'h00) && !merge;
   end

   // Popped slots are zeroed so the pending map can simply OR every slot
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         rf_we_o      <= 1'b0;
         rf_clr_o     <= 1'b0;
         rf_waddr_o   <= '0;
         rf_wdata_o   <= '0;
         rf_mask_o    <= '0;
         rf_quarter_o <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_mask[i]    <= '0;
            q_quarter[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_mask[i] <= q_mask_stripped[i];
         end
         if (pop) begin
            q_mask[rd_ptr] <= 8'h00;
            rd_ptr         <= rd_ptr + 1'b1;
         end
         if (merge) begin
            q_mask[tail_ptr] <= q_mask_stripped[tail_ptr] | req_mask;
         end
         if (alloc) begin
            q_mask[wr_ptr]    <= req_mask;
            q_quarter[wr_ptr] <= clr_quarter_i;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         count <= count + (PW+1)'(alloc) - (PW+1)'(pop);

         rf_we_o      <= 1'b0;
         rf_clr_o     <= 1'b0;
         rf_waddr_o   <= '0;
         rf_wdata_o   <= '0;
         rf_mask_o    <= '0;
         rf_quarter_o <= '0;
         if (commit_we_i) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= commit_waddr_i;
            rf_wdata_o <= commit_wdata_i;
         end else if (pop && (head_mask != 8'h00)) begin
            rf_we_o      <= 1'b1;
            rf_clr_o     <= 1'b1;
            rf_mask_o    <= head_mask;
            rf_quarter_o <= q_quarter[rd_ptr];
         end
      end
   end

   always_comb begin
      pend = 32'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         pend = pend | (32'(q_mask[i]) << {q_quarter[i], 3'b000});
      end
      if (rf_clr_o) begin
         pend = pend | (32'(rf_mask_o) << {rf_quarter_o, 3'b000});
      end
      pend[0] = 1'b0;
   end

   assign pending_o   = pend;
   assign clr_ready_o = !full;
   assign busy_o      = !empty || rf_clr_o;

   always_comb begin
      for (int i = 0; i < NR_READ_PORTS; i++) begin
         hazard_o[i] = pend[raddr_i[i]];
      end
   end

endmodule

// File: tb/tb_cheri_regfile_clear_ctrl.sv
// Scoreboard bench for cheri_regfile_clear_ctrl: directed vectors queue expected rf ops, a monitor checks them.
module tb_cheri_regfile_clear_ctrl;

   logic            clk = 1'b0;
   logic            rstN;
   logic            clrValid, clrReady;
   logic [1:0]      clrQuarter;
   logic [7:0]      clrMask;
   logic            commitWe;
   logic [4:0]      commitWaddr;
   logic [31:0]     commitWdata;
   logic            rfWe, rfClr;
   logic [4:0]      rfWaddr;
   logic [31:0]     rfWdata;
   logic [7:0]      rfMask;
   logic [1:0]      rfQuarter;
   logic [1:0][4:0] raddr;
   logic [1:0]      hazard;
   logic [31:0]     pending;
   logic            busy;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic        clr;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [7:0]  mask;
      logic [1:0]  quarter;
   } rfOp_t;

   rfOp_t expQ[$];

   always #5 clk = ~clk;

   cheri_regfile_clear_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .NR_READ_PORTS(2)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .clr_valid_i(clrValid), .clr_ready_o(clrReady),
      .clr_quarter_i(clrQuarter), .clr_mask_i(clrMask),
      .commit_we_i(commitWe), .commit_waddr_i(commitWaddr), .commit_wdata_i(commitWdata),
      .rf_we_o(rfWe), .rf_clr_o(rfClr), .rf_waddr_o(rfWaddr), .rf_wdata_o(rfWdata),
      .rf_mask_o(rfMask), .rf_quarter_o(rfQuarter),
      .raddr_i(raddr), .hazard_o(hazard), .pending_o(pending), .busy_o(busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs; a commit always lands on rf_* next cycle, so its expectation is queued here
   task automatic applyStimulus(input logic v, input logic [1:0] q, input logic [7:0] m,
                                input logic cwe, input logic [4:0] ca, input logic [31:0] cd);
      clrValid    = v;
      clrQuarter  = q;
      clrMask     = m;
      commitWe    = cwe;
      commitWaddr = ca;
      commitWdata = cd;
      if (cwe) expQ.push_back('{1'b0, ca, cd, 8'h00, 2'b00});
      @(posedge clk);
      #1;
   endtask

   task automatic pushClear(input logic [1:0] q, input logic [7:0] m);
      expQ.push_back('{1'b1, 5'd0, 32'h0, m, q});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 5'd0, 32'h0);
   endtask

   // Every rf write must match the oldest queued expectation, in order
   always @(negedge clk) begin
      if (rstN && rfWe) begin
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL rf_op unexpected: clr=%b waddr=%0d wdata=%h mask=%h q=%0d, expected none",
                     rfClr, rfWaddr, rfWdata, rfMask, rfQuarter);
         end else begin
            rfOp_t e;
            rfOp_t got;
            e   = expQ.pop_front();
            got = '{rfClr, rfWaddr, rfWdata, rfMask, rfQuarter};
            if (got !== e) begin
               testsFailed++;
               $display("[TB] FAIL rf_op: got clr=%b waddr=%0d wdata=%h mask=%h q=%0d, expected clr=%b waddr=%0d wdata=%h mask=%h q=%0d",
                        got.clr, got.waddr, got.wdata, got.mask, got.quarter,
                        e.clr, e.waddr, e.wdata, e.mask, e.quarter);
            end
         end
      end
   end

   initial begin
      rstN = 1'b0;
      clrValid = 1'b0; clrQuarter = '0; clrMask = '0;
      commitWe = 1'b0; commitWaddr = '0; commitWdata = '0;
      raddr = '0;
      #12;
      checkOutput("reset_rf_we", 32'(rfWe), 32'd0);
      checkOutput("reset_pending", pending, 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_hazard", 32'(hazard), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_ready", 32'(clrReady), 32'd1);

      // T1: lone clear reaches rf_* two cycles after acceptance
      applyStimulus(1'b1, 2'd1, 8'h0F, 1'b0, 5'd0, 32'h0);
      pushClear(2'd1, 8'h0F);
      checkOutput("t1_no_clr_yet", 32'(rfClr), 32'd0);
      checkOutput("t1_pending_queued", pending, 32'h0000_0F00);
      idle(1);
      checkOutput("t1_clr_issued", 32'(rfClr), 32'd1);
      checkOutput("t1_pending_on_rf", pending, 32'h0000_0F00);
      idle(1);
      checkOutput("t1_pending_done", pending, 32'h0);
      checkOutput("t1_busy_done", 32'(busy), 32'd0);

      // T2: five commits to x3 starve the clear and strip bit 3
      raddr[0] = 5'd3;
      raddr[1] = 5'd5;
      applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 5'd0, 32'h0);
      checkOutput("t2_pending_queued", pending, 32'h0000_00FE);
      checkOutput("t2_hazard_both", 32'(hazard), 32'd3);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 5'd3, 32'hA000_0000 + 32'(k));
         if (k == 0) begin
            checkOutput("t2_pending_stripped", pending, 32'h0000_00F6);
            checkOutput("t2_hazard_x3_gone", 32'(hazard), 32'd2);
         end
      end
      pushClear(2'd0, 8'hF7);
      idle(1);
      checkOutput("t2_clr_issued", 32'(rfClr), 32'd1);
      checkOutput("t2_hazard_x5_on_rf", 32'(hazard), 32'd2);
      idle(1);
      checkOutput("t2_hazard_clear", 32'(hazard), 32'd0);

      // T3: commit to x16 empties the queued q=2 entry, which is discarded silently
      raddr = '0;
      applyStimulus(1'b1, 2'd2, 8'h01, 1'b0, 5'd0, 32'h0);
      checkOutput("t3_pending16", pending, 32'h0001_0000);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 5'd16, 32'h0000_1616);
      checkOutput("t3_pending_fell", pending, 32'h0);
      checkOutput("t3_busy_zero_entry", 32'(busy), 32'd1);
      idle(1);
      checkOutput("t3_no_rf_op", 32'(rfWe), 32'd0);
      checkOutput("t3_busy_after_drop", 32'(busy), 32'd0);

      // T4: fill the FIFO under commit stall, then drain one per cycle
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 2'd1, 8'h01 << k, 1'b1, 5'd20, 32'h4000 + 32'(k));
      end
      checkOutput("t4_full_ready", 32'(clrReady), 32'd0);
      applyStimulus(1'b1, 2'd1, 8'h10, 1'b1, 5'd20, 32'h4004);
      checkOutput("t4_still_full", 32'(clrReady), 32'd0);
      for (int k = 0; k < 4; k++) pushClear(2'd1, 8'h01 << k);
      applyStimulus(1'b1, 2'd1, 8'h10, 1'b0, 5'd0, 32'h0);
      checkOutput("t4_ready_back", 32'(clrReady), 32'd1);
      checkOutput("t4_first_mask", 32'(rfMask), 32'h01);
      idle(4);
      checkOutput("t4_drained", 32'(busy), 32'd0);

      // T5: register 0 never shows pending, but the clear still issues
      applyStimulus(1'b1, 2'd0, 8'h01, 1'b0, 5'd0, 32'h0);
      pushClear(2'd0, 8'h01);
      checkOutput("t5_pending0", pending, 32'h0);
      checkOutput("t5_hazard0", 32'(hazard), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd1);
      idle(1);
      checkOutput("t5_clr_waddr", 32'(rfWaddr), 32'd0);
      checkOutput("t5_clr_mask", 32'(rfMask), 32'h01);
      idle(1);

      // T6: back-to-back q=3 requests under commit stall
      applyStimulus(1'b1, 2'd3, 8'h01, 1'b1, 5'd1, 32'h6001);
      applyStimulus(1'b1, 2'd3, 8'h80, 1'b1, 5'd1, 32'h6002);
      checkOutput("t6_pending", pending, 32'h8100_0000);
`ifdef CHERI_CLR_MERGE_EN
      pushClear(2'd3, 8'h81);
`else
      pushClear(2'd3, 8'h01);
      pushClear(2'd3, 8'h80);
`endif
      idle(3);
      checkOutput("t6_busy_done", 32'(busy), 32'd0);

      // T7: zero-mask request consumes the handshake only
      applyStimulus(1'b1, 2'd2, 8'h00, 1'b0, 5'd0, 32'h0);
      checkOutput("t7_busy", 32'(busy), 32'd0);
      checkOutput("t7_pending", pending, 32'h0);
      idle(2);

      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
